// File: rtl/reg_dump_unit_pkg.sv
// otter_dbg_pkg: shared types and widths for the register dump engine.
//   REG_IDX_W  - register index width (5 bits, x0..x31)
//   REG_DATA_W - register data width (32 bits)
//   dump_state_t - dump sequencer states, shared by the RTL and anything
//                  that wants to decode them.
//   idx_inc    - modulo-32 index increment used when walking the range.
package otter_dbg_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    FIN  = 3'd4
  } dump_state_t;

  // Wraps naturally at the index width, so x31 is followed by x0.
  function automatic logic [REG_IDX_W-1:0] idx_inc(input logic [REG_IDX_W-1:0] idx);
    return idx + REG_IDX_W'(1);
  endfunction

endpackage

// File: rtl/reg_dump_unit_if.sv
// reg_dump_unit_if: valid/ready stream carrying dumped register beats.
//   DOUT      - beat data (register value or checksum)
//   DOUT_IDX  - register index of the beat (0 on the checksum beat)
//   DOUT_LAST - final beat of the dump
//   DOUT_CSUM - beat carries the checksum
//   VALID     - producer has a beat
//   READY     - consumer accepts the beat when VALID & READY
// modport master: the dump engine (producer); modport slave: the consumer.
interface reg_dump_unit_if;
  import otter_dbg_pkg::*;

  logic [REG_DATA_W-1:0] DOUT;
  logic [REG_IDX_W-1:0]  DOUT_IDX;
  logic                  DOUT_LAST;
  logic                  DOUT_CSUM;
  logic                  VALID;
  logic                  READY;

  modport master (
    output DOUT, DOUT_IDX, DOUT_LAST, DOUT_CSUM, VALID,
    input  READY
  );

  modport slave (
    input  DOUT, DOUT_IDX, DOUT_LAST, DOUT_CSUM, VALID,
    output READY
  );

endinterface

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: debug read-out engine for the OTTER register file.
// On START (in IDLE) it walks register indices FIRST..LAST (wrapping mod 32)
// through an asynchronous read port and streams each value on the dump bus.
//   CLK, RST_N   - clock, synchronous active-low reset
//   START        - single-cycle request, honoured only when idle
//   FIRST, LAST  - inclusive index range, captured on an accepted START
//   RF_ADR/RF_RD - register-file read address / combinational read data
//   BUSY         - high in every state except IDLE
//   DONE         - one-cycle pulse after the final beat is accepted
//   dump         - stream master (DOUT, DOUT_IDX, DOUT_LAST, DOUT_CSUM,
//                  VALID, READY)
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends a beat holding the
// XOR of every register word sent, flagged with DOUT_CSUM and DOUT_LAST.
module reg_dump_unit
  import otter_dbg_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [REG_IDX_W-1:0]  FIRST,
  input  logic [REG_IDX_W-1:0]  LAST,
  output logic [REG_IDX_W-1:0]  RF_ADR,
  input  logic [REG_DATA_W-1:0] RF_RD,
  output logic                  BUSY,
  output logic                  DONE,
  reg_dump_unit_if.master       dump
);

  dump_state_t state_q, state_d;

  logic [REG_IDX_W-1:0]  idx_q;
  logic [REG_IDX_W-1:0]  last_q;
  logic [REG_IDX_W-1:0]  rf_adr_q;
  logic [REG_DATA_W-1:0] dout_q;
  logic [REG_IDX_W-1:0]  dout_idx_q;
  logic                  dout_last_q;
  logic                  valid;
  logic                  done;
  logic                  at_last;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [REG_DATA_W-1:0] csum_q;
  logic                  dout_csum_q;
`endif

  assign at_last = (idx_q == last_q);

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. The final register beat branches to
  // the checksum beat when that feature is built in, otherwise straight to FIN.
  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) state_d = READ;
      end
      READ: begin
        state_d = SEND;
      end
      SEND: begin
        valid = 1'b1;
        if (dump.READY) begin
          if (at_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = FIN;
`endif
          end else begin
            state_d = READ;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        valid = 1'b1;
        if (dump.READY) state_d = FIN;
      end
`endif
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath. Output registers only change in READ (loading the next beat)
  // or on a handshake, so the beat stays stable while the consumer stalls.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idx_q       <= '0;
      last_q      <= '0;
      rf_adr_q    <= '0;
      dout_q      <= '0;
      dout_idx_q  <= '0;
      dout_last_q <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= '0;
      dout_csum_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            idx_q       <= FIRST;
            last_q      <= LAST;
            dout_last_q <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q      <= '0;
            dout_csum_q <= 1'b0;
`endif
          end
        end
        READ: begin
          rf_adr_q   <= idx_q;
          dout_q     <= RF_RD;
          dout_idx_q <= idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
          dout_last_q <= 1'b0;
`else
          dout_last_q <= at_last;
`endif
        end
        SEND: begin
          if (dump.READY) begin
            if (at_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
              // Checksum beat is built directly so CSUM can present it at once.
              csum_q      <= csum_q ^ dout_q;
              dout_q      <= csum_q ^ dout_q;
              dout_idx_q  <= '0;
              dout_csum_q <= 1'b1;
              dout_last_q <= 1'b1;
`else
              dout_last_q <= 1'b0;
`endif
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              csum_q <= csum_q ^ dout_q;
`endif
              idx_q <= idx_inc(idx_q);
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (dump.READY) begin
            dout_csum_q <= 1'b0;
            dout_last_q <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // RF_ADR follows the index only while reading and otherwise holds the
  // last address it drove, so the shared read mux sees no glitching.
  assign RF_ADR = (state_q == READ) ? idx_q : rf_adr_q;

  assign BUSY = (state_q != IDLE);
  assign DONE = done;

  assign dump.DOUT      = dout_q;
  assign dump.DOUT_IDX  = dout_idx_q;
  assign dump.DOUT_LAST = dout_last_q;
  assign dump.VALID     = valid;
`ifdef REG_DUMP_CHECKSUM_EN
  assign dump.DOUT_CSUM = dout_csum_q;
`else
  assign dump.DOUT_CSUM = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: directed self-checking bench for reg_dump_unit.
// A behavioural register file answers RF_ADR combinationally; applyStimulus
// runs one dump, optionally stalling READY on one index or pulsing START
// mid-dump, and records every accepted beat. Each test task compares the
// recorded beats and timing against hand-computed values.
// Honours REG_DUMP_CHECKSUM_EN (adds the checksum beat to expectations).
module tb_reg_dump_unit;
  import otter_dbg_pkg::*;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [4:0]  FIRST = '0;
  logic [4:0]  LAST = '0;
  logic [4:0]  RF_ADR;
  logic [31:0] RF_RD;
  logic        BUSY;
  logic        DONE;
  logic [31:0] rf [32];

  reg_dump_unit_if dump_if ();

  reg_dump_unit dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .FIRST (FIRST),
    .LAST  (LAST),
    .RF_ADR(RF_ADR),
    .RF_RD (RF_RD),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .dump  (dump_if)
  );

  assign RF_RD = rf[RF_ADR];

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [31:0] q_data [$];
  logic [4:0]  q_idx [$];
  logic        q_last [$];
  logic        q_csum [$];
  int first_valid, start_edge, last_hs, done_cyc, stall_samples, unstable;
  bit timed_out;

  // Runs one dump from first..last and records every accepted beat.
  task automatic applyStimulus(input logic [4:0] first, input logic [4:0] last,
                               input int stall_idx, input int stall_n, input int inject_at);
    int stall_left;
    bit in_stall;
    logic [31:0] hd;
    logic [4:0] hi;
    logic hl;
    q_data.delete(); q_idx.delete(); q_last.delete(); q_csum.delete();
    first_valid = -1; last_hs = -1; done_cyc = -1;
    stall_samples = 0; unstable = 0; timed_out = 1;
    stall_left = stall_n; in_stall = 0; hd = '0; hi = '0; hl = 1'b0;
    @(negedge CLK);
    START = 1'b1; FIRST = first; LAST = last; start_edge = cyc + 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      START = (k == inject_at);
      if (k == inject_at) begin FIRST = 5'd0; LAST = 5'd0; end
      if (dump_if.VALID) begin
        if (first_valid < 0) first_valid = cyc;
        if (in_stall && ({dump_if.DOUT, dump_if.DOUT_IDX, dump_if.DOUT_LAST} !== {hd, hi, hl}))
          unstable++;
        if (stall_left > 0 && dump_if.DOUT_IDX == stall_idx[4:0]) begin
          if (!in_stall) begin
            hd = dump_if.DOUT; hi = dump_if.DOUT_IDX; hl = dump_if.DOUT_LAST; in_stall = 1;
          end
          stall_left--; stall_samples++;
          dump_if.READY = 1'b0;
        end else begin
          dump_if.READY = 1'b1;
          in_stall = 0;
          q_data.push_back(dump_if.DOUT); q_idx.push_back(dump_if.DOUT_IDX);
          q_last.push_back(dump_if.DOUT_LAST); q_csum.push_back(dump_if.DOUT_CSUM);
          last_hs = cyc;
        end
      end else begin
        if (in_stall) unstable++;
        dump_if.READY = 1'b1;
      end
      if (DONE) begin done_cyc = cyc; timed_out = 0; break; end
    end
    START = 1'b0;
    dump_if.READY = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; dump_if.READY = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({dump_if.VALID, BUSY, DONE} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 000", {dump_if.VALID, BUSY, DONE});
    end
    checks++;
    if (dump_if.DOUT !== 32'h0) begin
      failures++; $display("FAIL reset_dout: got %h expected 0", dump_if.DOUT);
    end
    checks++;
    if ({RF_ADR, dump_if.DOUT_IDX} !== 10'h0) begin
      failures++; $display("FAIL reset_idx: got %h expected 0", {RF_ADR, dump_if.DOUT_IDX});
    end
    checks++;
    if ({dump_if.DOUT_LAST, dump_if.DOUT_CSUM} !== 2'b00) begin
      failures++; $display("FAIL reset_flags: got %b expected 00", {dump_if.DOUT_LAST, dump_if.DOUT_CSUM});
    end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single();
    logic [38:0] got, exp;
    rf[5] = 32'hDEADBEEF;
    applyStimulus(5'd5, 5'd5, -1, 0, -1);
    checks++;
    if (timed_out || q_idx.size() != 1 + CS) begin
      failures++; $display("FAIL single_count: got %0d beats (timeout=%0d) expected %0d", q_idx.size(), timed_out, 1 + CS);
    end
    got = (q_idx.size() > 0) ? {q_idx[0], q_data[0], q_last[0], q_csum[0]} : 'x;
    exp = {5'd5, 32'hDEADBEEF, (CS == 0), 1'b0};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL single_beat: got %h expected %h", got, exp);
    end
    checks++;
    if (first_valid - start_edge != 1) begin
      failures++; $display("FAIL single_latency: got %0d expected 1", first_valid - start_edge);
    end
    checks++;
    if (done_cyc - last_hs != 1) begin
      failures++; $display("FAIL single_done: got %0d expected 1", done_cyc - last_hs);
    end
`ifdef REG_DUMP_CHECKSUM_EN
    got = (q_idx.size() > 1) ? {q_idx[1], q_data[1], q_last[1], q_csum[1]} : 'x;
    exp = {5'd0, 32'hDEADBEEF, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL single_csum: got %h expected %h", got, exp);
    end
`endif
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE} !== 2'b00) begin
      failures++; $display("FAIL single_idle: got %b expected 00", {BUSY, DONE});
    end
  endtask

  task automatic test_wrap();
    logic [38:0] got, exp;
    logic [4:0] e;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    applyStimulus(5'd30, 5'd1, -1, 0, -1);
    checks++;
    if (timed_out || q_idx.size() != 4 + CS) begin
      failures++; $display("FAIL wrap_count: got %0d expected %0d", q_idx.size(), 4 + CS);
    end
    for (int i = 0; i < 4; i++) begin
      e = 5'(30 + i);
      got = (q_idx.size() > i) ? {q_idx[i], q_data[i], q_last[i], q_csum[i]} : 'x;
      exp = {e, {27'd0, e}, (i == 3 && CS == 0), 1'b0};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL wrap_beat %0d: got %h expected %h", i, got, exp);
      end
    end
    checks++;
    if (done_cyc - first_valid != 7 + CS) begin
      failures++; $display("FAIL wrap_rate: got %0d expected %0d", done_cyc - first_valid, 7 + CS);
    end
  endtask

  task automatic test_full_range();
    logic [38:0] got, exp;
    logic [4:0] e;
    logic [31:0] x;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : (32'h1000_0000 | 32'(i));
    applyStimulus(5'd1, 5'd0, -1, 0, -1);
    checks++;
    if (timed_out || q_idx.size() != 32 + CS) begin
      failures++; $display("FAIL full_count: got %0d expected %0d", q_idx.size(), 32 + CS);
    end
    x = '0;
    for (int i = 0; i < 32; i++) begin
      e = 5'(1 + i);
      got = (q_idx.size() > i) ? {q_idx[i], q_data[i], q_last[i], q_csum[i]} : 'x;
      exp = {e, (e == 0) ? 32'h0 : (32'h1000_0000 | {27'd0, e}), (i == 31 && CS == 0), 1'b0};
      x = x ^ exp[33:2];
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL full_beat %0d: got %h expected %h", i, got, exp);
      end
    end
`ifdef REG_DUMP_CHECKSUM_EN
    checks++;
    if ((q_data.size() > 32 ? q_data[32] : 32'hx) !== x) begin
      failures++; $display("FAIL full_csum: got %h expected %h", q_data.size() > 32 ? q_data[32] : 32'hx, x);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [38:0] got, exp;
    logic [4:0] e;
    for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | 32'(i);
    applyStimulus(5'd2, 5'd4, 3, 5, -1);
    checks++;
    if (stall_samples != 5 || unstable != 0) begin
      failures++; $display("FAIL bp_stable: got stalls=%0d unstable=%0d expected 5 and 0", stall_samples, unstable);
    end
    checks++;
    if (timed_out || q_idx.size() != 3 + CS) begin
      failures++; $display("FAIL bp_count: got %0d expected %0d", q_idx.size(), 3 + CS);
    end
    for (int i = 0; i < 3; i++) begin
      e = 5'(2 + i);
      got = (q_idx.size() > i) ? {q_idx[i], q_data[i], q_last[i], q_csum[i]} : 'x;
      exp = {e, 32'hA500_0000 | {27'd0, e}, (i == 2 && CS == 0), 1'b0};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL bp_beat %0d: got %h expected %h", i, got, exp);
      end
    end
    checks++;
    if (done_cyc - first_valid != 10 + CS) begin
      failures++; $display("FAIL bp_timing: got %0d expected %0d", done_cyc - first_valid, 10 + CS);
    end
  endtask

  task automatic test_busy_start();
    logic [31:0] idx_seen;
    applyStimulus(5'd10, 5'd12, -1, 0, 2);
    idx_seen = '0;
    for (int i = 0; i < 3 && i < q_idx.size(); i++) idx_seen[i*5 +: 5] = q_idx[i];
    checks++;
    if (timed_out || q_idx.size() != 3 + CS || idx_seen[14:0] !== {5'd12, 5'd11, 5'd10}) begin
      failures++; $display("FAIL busy_start: got %0d beats idx %h expected %0d beats idx %h",
                           q_idx.size(), idx_seen[14:0], 3 + CS, {5'd12, 5'd11, 5'd10});
    end
    repeat (2) @(negedge CLK);
    checks++;
    if ({BUSY, dump_if.VALID} !== 2'b00) begin
      failures++; $display("FAIL busy_requeue: got %b expected 00", {BUSY, dump_if.VALID});
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    rf[7] = 32'h1234_5678;
    @(negedge CLK);
    START = 1'b1; FIRST = 5'd0; LAST = 5'd31;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin
      failures++; $display("FAIL mid_busy: got %b expected 1", BUSY);
    end
    RST_N = 1'b0;
    @(negedge CLK);
    checks++;
    if ({RF_ADR, dump_if.DOUT, dump_if.DOUT_IDX, dump_if.DOUT_LAST, dump_if.DOUT_CSUM,
         dump_if.VALID, BUSY, DONE} !== 47'h0) begin
      failures++; $display("FAIL mid_reset: got %h expected 0", {RF_ADR, dump_if.DOUT, dump_if.DOUT_IDX,
                           dump_if.DOUT_LAST, dump_if.DOUT_CSUM, dump_if.VALID, BUSY, DONE});
    end
    RST_N = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL mid_nodone: got %0d active cycles expected 0", dones);
    end
    applyStimulus(5'd7, 5'd7, -1, 0, -1);
    checks++;
    if (timed_out || (q_data.size() > 0 ? {q_idx[0], q_data[0]} : 37'hx) !== {5'd7, 32'h1234_5678}) begin
      failures++; $display("FAIL mid_restart: got %h expected %h",
                           q_data.size() > 0 ? {q_idx[0], q_data[0]} : 37'hx, {5'd7, 32'h1234_5678});
    end
  endtask

  task automatic test_checksum();
    logic [38:0] got, exp;
    rf[1] = 32'h0000_000F;
    rf[2] = 32'h0000_00F0;
    applyStimulus(5'd1, 5'd2, -1, 0, -1);
    checks++;
    if (timed_out || q_idx.size() != 2 + CS) begin
      failures++; $display("FAIL csum_count: got %0d expected %0d", q_idx.size(), 2 + CS);
    end
    got = (q_idx.size() > 1) ? {q_idx[1], q_data[1], q_last[1], q_csum[1]} : 'x;
    exp = {5'd2, 32'h0000_00F0, (CS == 0), 1'b0};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL csum_reg_beat: got %h expected %h", got, exp);
    end
`ifdef REG_DUMP_CHECKSUM_EN
    got = (q_idx.size() > 2) ? {q_idx[2], q_data[2], q_last[2], q_csum[2]} : 'x;
    exp = {5'd0, 32'h0000_00FF, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL csum_beat: got %h expected %h", got, exp);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    dump_if.READY = 1'b1;
    $display("[TB] reg_dump_unit bench start (checksum beat %0d)", CS);
    test_reset();
    test_single();
    test_wrap();
    test_full_range();
    test_backpressure();
    test_busy_start();
    test_reset_mid();
    test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Debug read-out engine for the OTTER register file. On a start pulse it walks a range of register indices through one asynchronous register-file read port and streams each 32-bit value out on a valid/ready interface toward the debug/UART path. It is the read-side counterpart to the CPU writeback path and sits beside the register file, sharing a read address mux with the decode stage while the core is halted.

## Interface
Parameters:
- none; widths fixed: 32-bit data, 5-bit register index.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  reset; one clock, reset is synchronous and active-low.
- START  in  1  single-cycle request; sampled only in IDLE.
- FIRST  in  5  first register index, captured on accepted START.
- LAST  in  5  last register index, captured on accepted START.
- RF_ADR  out  5  register-file read address.
- RF_RD  in  32  register-file read data, combinational from RF_ADR.
- DOUT  out  32  stream data.
- DOUT_IDX  out  5  register index of current beat.
- DOUT_LAST  out  1  high on final beat of the dump.
- DOUT_CSUM  out  1  high when current beat is the checksum beat.
- VALID  out  1  beat present.
- READY  in  1  consumer accepts beat when VALID&READY.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse after final beat accepted.

## Operation
- States: IDLE, READ, SEND, CSUM, FIN (shared enum).
- IDLE: START=1 captures FIRST into index counter, LAST into end register; -> READ. Otherwise stay.
- READ: RF_ADR=index; RF_RD registered into DOUT, index into DOUT_IDX; -> SEND.
- SEND: VALID=1, DOUT/DOUT_IDX/DOUT_LAST held stable until VALID&READY. On handshake: if index==LAST -> CSUM (macro on) or FIN (macro off); else index=index+1 mod 32, -> READ.
- CSUM: (macro on) DOUT=XOR of all words sent, DOUT_IDX=0, DOUT_CSUM=1, DOUT_LAST=1, VALID=1; on handshake -> FIN.
- FIN: DONE=1 for exactly one cycle; -> IDLE.
- Range wraps: beat count = ((LAST-FIRST) mod 32)+1. FIRST==LAST gives 1 beat; FIRST=LAST+1 gives 32 beats.
- DOUT_LAST high on the final register beat only when macro off; with macro on it is high only on the checksum beat.
- x0 is read like any other index (value 0).
- START while BUSY ignored; no queueing.
- Register writes during a dump are allowed; each beat reflects the value sampled in its READ cycle.
- RF_ADR holds last driven index outside READ.

## Timing
- Reset (RST_N=0 at edge): state IDLE; RF_ADR=0, DOUT=0, DOUT_IDX=0, DOUT_LAST=0, DOUT_CSUM=0, VALID=0, BUSY=0, DONE=0, checksum=0. Reset mid-dump aborts immediately; no DONE.
- START at edge n -> READ in cycle n+1 -> VALID high from cycle n+2.
- Minimum 2 cycles per beat (READ + SEND) with READY held high.
- DONE in the cycle after the last handshake; BUSY falls the cycle after DONE.
- VALID never drops without handshake; producer changes DOUT only after handshake.

## Configuration
- REG_DUMP_CHECKSUM_EN defined: 32-bit XOR accumulator cleared on accepted START, updated on every register handshake; extra CSUM beat appended.
- Undefined: no accumulator, no CSUM state; DOUT_CSUM tied 0; dump ends after last register beat.

## Structure
- Package otter_dbg_pkg: state enum dump_state_t, REG_IDX_W=5, REG_DATA_W=32.
- No sub-module; checksum is a single register inside the block.

## Test plan
- x5=0xDEADBEEF, FIRST=LAST=5, READY=1 -> one beat DOUT=0xDEADBEEF, DOUT_IDX=5, DOUT_LAST=1, VALID at START+2, DONE one cycle later.
- FIRST=30, LAST=1, xi=i -> beats idx 30,31,0,1 with data 30,31,0,1; last beat DOUT_LAST=1.
- FIRST=1, LAST=0 -> 32 beats, idx 1..31 then 0.
- READY low for 5 cycles during beat idx 3 -> VALID, DOUT, DOUT_IDX stable all 5 cycles; no skipped index.
- START pulsed while BUSY; RST_N low mid-dump -> second START ignored; after reset all outputs 0, no DONE, next START works.
- Macro on, x1=0x0F, x2=0xF0 dumped -> third beat DOUT=0xFF, DOUT_CSUM=1, DOUT_LAST=1; macro off -> two beats only.
